// File: rtl/mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter. One transaction owns the
// slave from request through response; simultaneous requests are round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_rdata,
    output logic                lsu_resp_err,

    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic                s_req_wen,
    output logic [DATA_W-1:0]   s_req_wdata,
    output logic [DATA_W/8-1:0] s_req_wstrb,
    input  logic                s_resp_valid,
    output logic                s_resp_ready,
    input  logic [DATA_W-1:0]   s_resp_rdata,
    input  logic                s_resp_err,

    output logic [1:0]          o_grant,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IFU  = 2'b01,
        OWN_LSU  = 2'b10
    } owner_t;

    state_t state_q;
    owner_t owner_q;
    logic   last_q;     // 1: LSU was granted last, so IFU wins the next tie

    logic own_ifu;
    logic own_lsu;
    logic own_req_valid;
    logic own_resp_ready;

    assign own_ifu = (owner_q == OWN_IFU);
    assign own_lsu = (owner_q == OWN_LSU);

    // Only an active owner's signals may steer the slave; a stale owner code is inert.
    assign own_req_valid  = (own_ifu & ifu_req_valid)  | (own_lsu & lsu_req_valid);
    assign own_resp_ready = (own_ifu & ifu_resp_ready) | (own_lsu & lsu_resp_ready);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ifu_req_valid && lsu_req_valid) begin
                        owner_q <= last_q ? OWN_IFU : OWN_LSU;
                        state_q <= S_REQ;
                    end else if (ifu_req_valid) begin
                        owner_q <= OWN_IFU;
                        state_q <= S_REQ;
                    end else if (lsu_req_valid) begin
                        owner_q <= OWN_LSU;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!own_req_valid) begin
                        owner_q <= OWN_NONE;
                        state_q <= S_IDLE;
                    end else if (s_req_ready) begin
                        last_q  <= own_lsu;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (s_resp_valid && own_resp_ready) begin
                        owner_q <= OWN_NONE;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    owner_q <= OWN_NONE;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through this block
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        s_req_valid    = 1'b0;
        s_req_addr     = '0;
        s_req_wen      = 1'b0;
        s_req_wdata    = '0;
        s_req_wstrb    = '0;
        s_resp_ready   = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_rdata = '0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_resp_rdata = '0;
        lsu_resp_err   = 1'b0;

        if (state_q == S_REQ) begin
            s_req_valid   = own_req_valid;
            ifu_req_ready = own_ifu & s_req_ready;
            lsu_req_ready = own_lsu & s_req_ready;
            if (own_ifu) begin
                s_req_addr = ifu_req_addr;
            end else if (own_lsu) begin
                s_req_addr  = lsu_req_addr;
                s_req_wen   = lsu_req_wen;
                s_req_wdata = lsu_req_wdata;
                s_req_wstrb = lsu_req_wstrb;
            end
        end

        if (state_q == S_RESP) begin
            s_resp_ready = own_resp_ready;
            if (own_ifu && s_resp_valid) begin
                ifu_resp_valid = 1'b1;
                ifu_resp_rdata = s_resp_rdata;
                ifu_resp_err   = s_resp_err;
            end
            if (own_lsu && s_resp_valid) begin
                lsu_resp_valid = 1'b1;
                lsu_resp_rdata = s_resp_rdata;
                lsu_resp_err   = s_resp_err;
            end
        end
    end

    assign o_grant = owner_q;
    assign o_busy  = (state_q != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter for the multicycle NPC core. It shares the single memory slave between the instruction fetch port (IFU, read-only) and the load/store port (LSU, read/write). Each port uses a request channel and a response channel, both with valid/ready handshakes. The arbiter grants one transaction at a time, request through response, and uses round-robin on simultaneous requests.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; `wstrb` width is DATA_W/8

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset: asserted at 0, takes effect immediately, released synchronously to clk
- ifu_req_valid  in  1  IFU read request valid
- ifu_req_ready  out  1  IFU request accepted
- ifu_req_addr  in  ADDR_W  IFU fetch address
- ifu_resp_valid  out  1  IFU response valid
- ifu_resp_ready  in  1  IFU accepts response
- ifu_resp_rdata  out  DATA_W  fetched word
- ifu_resp_err  out  1  slave error for IFU transaction
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted
- lsu_req_addr  in  ADDR_W  LSU address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wstrb  in  DATA_W/8  byte strobes
- lsu_resp_valid  out  1  LSU response valid
- lsu_resp_ready  in  1  LSU accepts response
- lsu_resp_rdata  out  DATA_W  read data; don't-care on writes
- lsu_resp_err  out  1  slave error for LSU transaction
- s_req_valid, s_req_ready, s_req_addr, s_req_wen, s_req_wdata, s_req_wstrb  out/in/out/out/out/out  matching widths  slave request channel
- s_resp_valid, s_resp_ready, s_resp_rdata, s_resp_err  in/out/in/in  matching widths  slave response channel
- o_grant  out  2  registered owner: 00 none, 01 IFU, 10 LSU
- o_busy  out  1  1 when state is not IDLE

## Operation
State machine: IDLE, REQ, RESP. Registers: `owner` (2 bits) and `last` (1 bit, last granted master).
- **IDLE**
  - If only one master asserts req_valid, owner ← that master and go to REQ.
  - If both assert it, owner ← the master not equal to `last`, then go to REQ.
  - No requests: stay in IDLE.
  - All req_ready, resp_valid and s_req_valid are 0.
- **REQ**
  - s_req_valid = owner's req_valid.
  - s_req_addr and s_req_wdata/wstrb/wen come from the owner. When IFU owns: wen = 0, wstrb = 0, wdata = 0.
  - Owner's req_ready = s_req_ready; non-owner req_ready = 0.
  - On handshake (valid & ready): `last` ← owner, go to RESP.
  - If the owner's req_valid is 0 (protocol violation): go to IDLE, owner ← none, no slave transaction.
- **RESP**
  - Owner's resp_valid = s_resp_valid; rdata and err pass through.
  - s_resp_ready = owner's resp_ready.
  - On handshake: owner ← none, go to IDLE.
- Outside RESP: s_resp_ready = 0, and all master resp_valid = 0.
- Non-owner ports: ready/valid outputs are always 0. Data outputs are 0 whenever the matching resp_valid is 0.
- The slave error bit passes through unchanged. The arbiter never generates responses itself.

## Timing
- **Reset:** state IDLE, owner 00, `last` = LSU (IFU wins the first tie). All outputs 0, including o_grant = 00 and o_busy = 0.
- **Reset mid-transaction:** the transaction is abandoned immediately and outputs go to reset values. A slave response arriving after release is ignored, because s_resp_ready = 0 in IDLE.
- **Latency:**
  - A request seen in IDLE at cycle N is presented on s_req at N+1.
  - With zero-wait ready and response, resp_valid at the master is at N+2 at the earliest.
  - Back-to-back transactions from one master: at most one per 3 cycles.
- **Arbitration:** a request arriving while another transaction is active waits, with req_ready held at 0, until IDLE.
- **Decision point:** the arbitration decision is made only in IDLE. Requests that appear or vanish during REQ/RESP do not alter owner.
- **Starvation bound:** with both masters continuously requesting, grants alternate strictly IFU, LSU, IFU, …
- **o_grant / o_busy:** these reflect registered state. o_grant changes on the cycle after the IDLE decision.

## Test plan
- **Reset:**
  - Drive rst = 0 mid-RESP of an LSU read → all outputs 0 asynchronously.
  - Release, then IFU request addr 0x8000_0000 → s_req_addr = 0x8000_0000 one cycle later, s_req_wen = 0.
- **Single IFU fetch, zero-wait slave returning 0x0000_0513:**
  - ifu_resp_rdata = 0x0000_0513, ifu_resp_valid at cycle 2.
  - lsu ports stay idle.
- **LSU write, addr 0x8000_1000, wdata 0xDEAD_BEEF, wstrb 0xF:**
  - Slave sees the exact values with wen = 1.
  - lsu_resp_valid follows the slave response.
- **Simultaneous IFU and LSU requests held continuously for 4 transactions:**
  - Grant order IFU, LSU, IFU, LSU.
  - o_grant sequence 01, 10, 01, 10.
- **Slave backpressure:**
  - s_req_ready low for 5 cycles → owner req_ready low for 5 cycles; state remains REQ.
  - s_resp_err = 1 with rdata 0 → lsu_resp_err = 1.
  - Master resp_ready low for 3 cycles → s_resp_ready low for those 3 cycles.
- **Protocol violation:** owner drops req_valid in REQ before the handshake → next cycle IDLE, o_grant 00, s_req_valid 0, no response issued.
